// File: rtl/pipe_track_if.sv
// pipe_track_if: D-stage inputs and per-stage destination/source tags
// exchanged between the pipeline datapath and the hazard-tracking block.
interface pipe_track_if;
   logic [31:0] instr_D;
   logic        valid_D;
   logic        stall;
   logic        flush_E;
   logic [4:0]  A3_E;
   logic [4:0]  A3_M;
   logic [4:0]  A3_W;
   logic [1:0]  Res_E;
   logic [1:0]  Res_M;
   logic [1:0]  Res_W;
   logic [4:0]  A1_E;
   logic [4:0]  A2_E;
   logic [4:0]  A2_M;
   logic        pending;

   modport master (
      output instr_D, valid_D, stall, flush_E,
      input  A3_E, A3_M, A3_W, Res_E, Res_M, Res_W, A1_E, A2_E, A2_M, pending
   );

   modport slave (
      input  instr_D, valid_D, stall, flush_E,
      output A3_E, A3_M, A3_W, Res_E, Res_M, Res_W, A1_E, A2_E, A2_M, pending
   );
endinterface

// File: rtl/pipe_track.sv
// pipe_track: decodes the instruction leaving D into a write-back tag
// (destination register + result class) and shifts it through E, M, W for
// the hazard unit. Stall or flush inserts a bubble into E; M and W always drain.
// Optional build macro PIPE_TRACK_PERF_EN adds saturating stall/retire counters.
module pipe_track #(
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_track_if.slave pt
`ifdef PIPE_TRACK_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] retire_cnt
`endif
);

   localparam logic [1:0] RES_NW  = 2'b00;
   localparam logic [1:0] RES_ALU = 2'b01;
   localparam logic [1:0] RES_DM  = 2'b10;
   localparam logic [1:0] RES_PC  = 2'b11;

   logic [5:0] op;
   logic [5:0] func;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;
   logic       unused_shamt;

   assign op           = pt.instr_D[31:26];
   assign rs           = pt.instr_D[25:21];
   assign rt           = pt.instr_D[20:16];
   assign rd           = pt.instr_D[15:11];
   assign func         = pt.instr_D[5:0];
   assign unused_shamt = ^pt.instr_D[10:6];

   logic [4:0] dec_a3;
   logic [1:0] dec_res;
   logic       load_e;

   logic [4:0] a3_e_d, a1_e_d, a2_e_d;
   logic [1:0] res_e_d;
   logic [4:0] a3_e_q, a3_m_q, a3_w_q;
   logic [1:0] res_e_q, res_m_q, res_w_q;
   logic [4:0] a1_e_q, a2_e_q, a2_m_q;

   // Decode destination register and result class of the D-stage instruction
   always_comb begin
      dec_a3  = 5'd0;
      dec_res = RES_NW;
      case (op)
         6'h00: begin
            case (func)
               6'h21, 6'h23, 6'h0A: begin   // addu, subu, movz (movz assumed to write)
                  dec_a3  = rd;
                  dec_res = RES_ALU;
               end
               6'h09: begin                 // jalr
                  dec_a3  = rd;
                  dec_res = RES_PC;
               end
               default: ;
            endcase
         end
         6'h0D, 6'h0E, 6'h0F: begin         // ori, xori, lui
            dec_a3  = rt;
            dec_res = RES_ALU;
         end
         6'h23: begin                       // lw
            dec_a3  = rt;
            dec_res = RES_DM;
         end
         6'h03: begin                       // jal
            dec_a3  = 5'd31;
            dec_res = RES_PC;
         end
         default: ;
      endcase
      // Writes to $0 are discarded, so they never create a hazard
      if (dec_a3 == 5'd0) begin
         dec_res = RES_NW;
      end
   end

   assign load_e = pt.valid_D & ~pt.stall & ~pt.flush_E;

   // Select decoded tag or bubble for the E stage
   always_comb begin
      a3_e_d  = 5'd0;
      res_e_d = RES_NW;
      a1_e_d  = 5'd0;
      a2_e_d  = 5'd0;
      if (load_e) begin
         a3_e_d  = dec_a3;
         res_e_d = dec_res;
         a1_e_d  = rs;
         a2_e_d  = rt;
      end
   end

   // Shift tags through E, M and W every edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a3_e_q  <= 5'd0;
         a3_m_q  <= 5'd0;
         a3_w_q  <= 5'd0;
         res_e_q <= RES_NW;
         res_m_q <= RES_NW;
         res_w_q <= RES_NW;
         a1_e_q  <= 5'd0;
         a2_e_q  <= 5'd0;
         a2_m_q  <= 5'd0;
      end else begin
         a3_e_q  <= a3_e_d;
         res_e_q <= res_e_d;
         a1_e_q  <= a1_e_d;
         a2_e_q  <= a2_e_d;
         a3_m_q  <= a3_e_q;
         res_m_q <= res_e_q;
         a2_m_q  <= a2_e_q;
         a3_w_q  <= a3_m_q;
         res_w_q <= res_m_q;
      end
   end

   assign pt.A3_E    = a3_e_q;
   assign pt.A3_M    = a3_m_q;
   assign pt.A3_W    = a3_w_q;
   assign pt.Res_E   = res_e_q;
   assign pt.Res_M   = res_m_q;
   assign pt.Res_W   = res_w_q;
   assign pt.A1_E    = a1_e_q;
   assign pt.A2_E    = a2_e_q;
   assign pt.A2_M    = a2_m_q;
   assign pt.pending = (res_e_q != RES_NW) | (res_m_q != RES_NW) | (res_w_q != RES_NW);

`ifdef PIPE_TRACK_PERF_EN
   logic             v_e_q, v_m_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

   // Saturating counter increments; a valid bit leaving M means a retirement
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if ((pt.stall | pt.flush_E) && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (v_m_q && (retire_cnt_q != {CNT_W{1'b1}})) begin
         retire_cnt_d = retire_cnt_q + 1'b1;
      end
   end

   // Per-stage valid bits and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_e_q        <= 1'b0;
         v_m_q        <= 1'b0;
         stall_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         v_e_q        <= load_e;
         v_m_q        <= v_e_q;
         stall_cnt_q  <= stall_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_track.sv
// tb_pipe_track: directed vectors for pipe_track with hand-computed tags.
module tb_pipe_track;
   localparam int TB_CNT_W = 8;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   pipe_track_if pt_bus ();

`ifdef PIPE_TRACK_PERF_EN
   logic [TB_CNT_W-1:0] stall_cnt;
   logic [TB_CNT_W-1:0] retire_cnt;
`endif

   pipe_track #(.CNT_W(TB_CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pt    (pt_bus)
`ifdef PIPE_TRACK_PERF_EN
      ,
      .stall_cnt  (stall_cnt),
      .retire_cnt (retire_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl);
      pt_bus.instr_D = ins;
      pt_bus.valid_D = v;
      pt_bus.stall   = st;
      pt_bus.flush_E = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      step(32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] func);
      return {6'd0, rs, rt, rd, 5'd0, func};
   endfunction

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      pt_bus.instr_D = 32'd0;
      pt_bus.valid_D = 1'b0;
      pt_bus.stall   = 1'b0;
      pt_bus.flush_E = 1'b0;
      #12;
      chk("rst_A3_E", pt_bus.A3_E, 0);
      chk("rst_Res_W", pt_bus.Res_W, 0);
      chk("rst_pending", pt_bus.pending, 0);
      rst_n = 1'b1;

      // lw $5, then reset asynchronously between edges
      step(i_type(6'h23, 5'd0, 5'd5, 16'd0), 1'b1, 1'b0, 1'b0);
      chk("lw5_A3_E", pt_bus.A3_E, 5);
      chk("lw5_Res_E", pt_bus.Res_E, 2);
      bubble();
      chk("lw5_A3_M", pt_bus.A3_M, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_A3_M", pt_bus.A3_M, 0);
      chk("mid_rst_Res_M", pt_bus.Res_M, 0);
      chk("mid_rst_pending", pt_bus.pending, 0);
      #1 rst_n = 1'b1;

      // lw $8 followed by a one-cycle stall
      step(i_type(6'h23, 5'd0, 5'd8, 16'd0), 1'b1, 1'b0, 1'b0);
      chk("lw8_A3_E", pt_bus.A3_E, 8);
      chk("lw8_Res_E", pt_bus.Res_E, 2);
      chk("lw8_pending", pt_bus.pending, 1);
      step(i_type(6'h23, 5'd0, 5'd8, 16'd0), 1'b1, 1'b1, 1'b0);
      chk("stall_A3_E", pt_bus.A3_E, 0);
      chk("stall_Res_E", pt_bus.Res_E, 0);
      chk("stall_A3_M", pt_bus.A3_M, 8);
      chk("stall_Res_M", pt_bus.Res_M, 2);
      step(i_type(6'h23, 5'd0, 5'd8, 16'd0), 1'b1, 1'b1, 1'b1);
      chk("stfl_A3_E", pt_bus.A3_E, 0);
      chk("stfl_A1_E", pt_bus.A1_E, 0);
      chk("stfl_A3_M", pt_bus.A3_M, 0);
      chk("lw8_A3_W", pt_bus.A3_W, 8);
      chk("lw8_Res_W", pt_bus.Res_W, 2);
      step(i_type(6'h0D, 5'd2, 5'd4, 16'd1), 1'b1, 1'b0, 1'b1);
      chk("flush_A3_E", pt_bus.A3_E, 0);
      chk("flush_Res_E", pt_bus.Res_E, 0);

      // jal then jalr $9 (rs = 31)
      step({6'h03, 26'h0}, 1'b1, 1'b0, 1'b0);
      chk("jal_A3_E", pt_bus.A3_E, 31);
      chk("jal_Res_E", pt_bus.Res_E, 3);
      step(r_type(5'd31, 5'd0, 5'd9, 6'h09), 1'b1, 1'b0, 1'b0);
      chk("jalr_A3_E", pt_bus.A3_E, 9);
      chk("jalr_Res_E", pt_bus.Res_E, 3);
      chk("jalr_A1_E", pt_bus.A1_E, 31);
      chk("jal_A3_M", pt_bus.A3_M, 31);
      chk("jal_Res_M", pt_bus.Res_M, 3);

      // addu $0, $1, $2: write to $0 is not a hazard
      step(r_type(5'd1, 5'd2, 5'd0, 6'h21), 1'b1, 1'b0, 1'b0);
      chk("addu0_A3_E", pt_bus.A3_E, 0);
      chk("addu0_Res_E", pt_bus.Res_E, 0);
      chk("addu0_A1_E", pt_bus.A1_E, 1);
      chk("addu0_A2_E", pt_bus.A2_E, 2);
      chk("jalr_A3_M", pt_bus.A3_M, 9);
      bubble();
      chk("drain1_pending", pt_bus.pending, 1);
      bubble();
      chk("drain2_pending", pt_bus.pending, 0);

      // sw $7, 4($3)
      step(i_type(6'h2B, 5'd3, 5'd7, 16'd4), 1'b1, 1'b0, 1'b0);
      chk("sw_Res_E", pt_bus.Res_E, 0);
      chk("sw_A3_E", pt_bus.A3_E, 0);
      chk("sw_A1_E", pt_bus.A1_E, 3);
      chk("sw_A2_E", pt_bus.A2_E, 7);
      chk("sw_pending", pt_bus.pending, 0);

      // movz $6, $4, $5 (always tagged as writing)
      step(r_type(5'd4, 5'd5, 5'd6, 6'h0A), 1'b1, 1'b0, 1'b0);
      chk("sw_A2_M", pt_bus.A2_M, 7);
      chk("movz_A3_E", pt_bus.A3_E, 6);
      chk("movz_Res_E", pt_bus.Res_E, 1);

      // subu $10, $11, $12
      step(r_type(5'd11, 5'd12, 5'd10, 6'h23), 1'b1, 1'b0, 1'b0);
      chk("subu_A3_E", pt_bus.A3_E, 10);
      chk("subu_Res_E", pt_bus.Res_E, 1);
      chk("movz_A2_M", pt_bus.A2_M, 5);

      // xori $0, $1, 1: destination $0 forces NW
      step(i_type(6'h0E, 5'd1, 5'd0, 16'd1), 1'b1, 1'b0, 1'b0);
      chk("xori0_Res_E", pt_bus.Res_E, 0);
      chk("xori0_A1_E", pt_bus.A1_E, 1);

      // lui $12
      step(i_type(6'h0F, 5'd0, 5'd12, 16'h1234), 1'b1, 1'b0, 1'b0);
      chk("lui_A3_E", pt_bus.A3_E, 12);
      chk("lui_Res_E", pt_bus.Res_E, 1);

      // beq $13, $14 carries sources but no destination
      step(i_type(6'h04, 5'd13, 5'd14, 16'd8), 1'b1, 1'b0, 1'b0);
      chk("beq_A3_E", pt_bus.A3_E, 0);
      chk("beq_Res_E", pt_bus.Res_E, 0);
      chk("beq_A2_E", pt_bus.A2_E, 14);
      chk("lui_A3_M", pt_bus.A3_M, 12);

      // invalid D slot is a bubble even with a real-looking encoding
      step(i_type(6'h23, 5'd1, 5'd9, 16'd0), 1'b0, 1'b0, 1'b0);
      chk("invalid_A3_E", pt_bus.A3_E, 0);
      chk("invalid_A2_E", pt_bus.A2_E, 0);

`ifdef PIPE_TRACK_PERF_EN
      // three stall/flush edges since the mid-stream reset
      chk("stall_cnt_3", stall_cnt, 3);
      for (int i = 0; i < 300; i++) begin
         step(32'd0, 1'b0, 1'b1, 1'b0);
      end
      chk("stall_cnt_sat", stall_cnt, 255);

      rst_n = 1'b0;
      #1;
      chk("cnt_rst_stall", stall_cnt, 0);
      chk("cnt_rst_retire", retire_cnt, 0);
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step(i_type(6'h0D, 5'd0, 5'(i), 16'd3), 1'b1, 1'b0, 1'b0);
      end
      chk("retire_after_5", retire_cnt, 3);
      bubble();
      chk("retire_plus1", retire_cnt, 4);
      bubble();
      chk("retire_5", retire_cnt, 5);
      bubble();
      chk("retire_hold", retire_cnt, 5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
